alu_seq_exec: RTL and testbench

- Execute-side consumer of the 4-bit ALU control code: takes operands plus `alu_control`, performs the operation and returns a registered result with zero flag.
- Used by the multi-cycle datapath. Single-cycle ops complete in 1 cycle; shifts iterate one bit per cycle to keep the barrel shifter out of the critical path.
- Valid/ready handshake on both sides.

---
 rtl/alu_seq_exec.sv | 143 ++++++++++++++
 tb/tb_alu_seq_exec.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Execute-side ALU with valid/ready handshakes. Single-cycle ops return in one cycle;
// shifts iterate one bit per cycle to keep a barrel shifter out of the critical path.
module alu_seq_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            alu_control_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  state_t                  state, state_nxt;
  logic [SHAMT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   work, work_nxt;
  logic [DATA_WIDTH-1:0]   result, result_nxt;
  logic [3:0]              op, op_nxt;
  logic                    zero, zero_nxt;
  logic                    out_valid, out_valid_nxt;
  logic [DATA_WIDTH-1:0]   alu_val, shifted;
  logic [SHAMT_WIDTH-1:0]  shamt;
  logic                    accept, is_shift;

  assign in_ready_o  = (state == IDLE) && (!out_valid || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign shamt       = b_i[SHAMT_WIDTH-1:0];
  assign is_shift    = (alu_control_i == OP_SLL) || (alu_control_i == OP_SRL) ||
                       (alu_control_i == OP_SRA);
  assign out_valid_o = out_valid;
  assign result_o    = result;
  assign zero_o      = zero;

  // Shifts only reach this path with a zero shift amount, so they pass A through.
  always_comb begin
    alu_val = a_i + b_i;
    case (alu_control_i)
      OP_SUB:  alu_val = a_i - b_i;
      OP_AND:  alu_val = a_i & b_i;
      OP_OR:   alu_val = a_i | b_i;
      OP_XOR:  alu_val = a_i ^ b_i;
      OP_SLT:  alu_val = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: alu_val = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_SLL, OP_SRL, OP_SRA: alu_val = a_i;
      default: alu_val = a_i + b_i;
    endcase
  end

  always_comb begin
    shifted = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
    case (op)
      OP_SLL:  shifted = work << 1;
      OP_SRL:  shifted = work >> 1;
      default: shifted = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    work_nxt      = work;
    op_nxt        = op;
    result_nxt    = result;
    zero_nxt      = zero;
    out_valid_nxt = out_valid;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            work_nxt      = a_i;
            cnt_nxt       = shamt;
            op_nxt        = alu_control_i;
            out_valid_nxt = 1'b0;
            state_nxt     = SHIFT;
          end else begin
            result_nxt    = alu_val;
            zero_nxt      = (alu_val == '0);
            out_valid_nxt = 1'b1;
          end
        end else if (out_valid && out_ready_i) begin
          out_valid_nxt = 1'b0;
        end
      end
      SHIFT: begin
        work_nxt = shifted;
        cnt_nxt  = cnt - SHAMT_WIDTH'(1);
        // Last step: publish the value being shifted in this cycle.
        if (cnt == SHAMT_WIDTH'(1)) begin
          result_nxt    = shifted;
          zero_nxt      = (shifted == '0);
          out_valid_nxt = 1'b1;
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      op        <= '0;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      work      <= work_nxt;
      op        <= op_nxt;
      result    <= result_nxt;
      zero      <= zero_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed vector table, handshake/reset corner sequences,
// and random operations compared with an arithmetic reference model.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_seq_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_control_i(alu_control), .a_i(a), .b_i(b), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .zero_o(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: shift results computed directly with whole-word operators.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] x,
                                          input logic [31:0] y);
    int sh;
    sh = int'(y[4:0]);
    case (c)
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: return x << sh;
      4'd7: return x >> sh;
      4'd8: return 32'($signed(x) >>> sh);
      4'd9: return (x < y) ? 32'd1 : 32'd0;
      default: return x + y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] y);
    if ((c == 4'd6 || c == 4'd7 || c == 4'd8) && y[4:0] != 5'd0) return 1 + int'(y[4:0]);
    return 1;
  endfunction

  // Called and returns at a falling edge; out_ready held high.
  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output logic z, output int lat);
    int n;
    alu_control = c; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stuck low");
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; alu_control = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
    res = result;
    z = zero;
  endtask

  vec_t        vecs[$];
  logic [31:0] res;
  logic        z;
  int          lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_control = 4'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", {31'd0, zero}, 32'd1);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    vecs.push_back('{4'b0000, 32'd5,          32'd7,          32'd12,         1});
    vecs.push_back('{4'b1000, 32'h8000_0000,  32'd4,          32'hF800_0000,  5});
    vecs.push_back('{4'b0111, 32'h8000_0000,  32'd4,          32'h0800_0000,  5});
    vecs.push_back('{4'b0110, 32'd1,          32'd31,         32'h8000_0000, 32});
    vecs.push_back('{4'b0110, 32'hDEAD_BEEF,  32'h20,         32'hDEAD_BEEF,  1});
    vecs.push_back('{4'b1000, 32'h1234_5678,  32'hFFFF_FFE0,  32'h1234_5678,  1});
    vecs.push_back('{4'b1111, 32'd10,         32'd20,         32'd30,         1});
    vecs.push_back('{4'b0100, 32'hFF00_FF00,  32'hFF00_FF00,  32'd0,          1});
    vecs.push_back('{4'b0010, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  1});
    vecs.push_back('{4'b1000, 32'h4000_0001,  32'd1,          32'h2000_0000,  2});
    foreach (vecs[i]) begin
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, res, z, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].exp_res == 32'd0});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (i == 0) begin
        #1;
        check("add_in_ready_high", {31'd0, in_ready}, 32'd1);
      end
    end

    // Back-to-back sub / slt / sltu with results on consecutive cycles.
    @(negedge clk); @(negedge clk);
    out_ready = 1'b1;
    alu_control = 4'b0001; a = 32'd3; b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    alu_control = 4'b0101; a = 32'hFFFF_FFFF; b = 32'd1;
    #1;
    check("b2b_sub_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_sub_result", result, 32'd0);
    check("b2b_sub_zero", {31'd0, zero}, 32'd1);
    check("b2b_ready1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    alu_control = 4'b1001;
    #1;
    check("b2b_slt_result", result, 32'd1);
    check("b2b_slt_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("b2b_sltu_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_sltu_result", result, 32'd0);
    @(negedge clk);
    check("b2b_drop_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure, then accept in the same cycle the held result is consumed.
    alu_control = 4'b0011; a = 32'hF0; b = 32'h0F; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_result_%0d", k), result, 32'hFF);
      check($sformatf("bp_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    alu_control = 4'b0000; a = 32'd2; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_result", result, 32'd5);
    @(negedge clk);

    // Reset during the third cycle of a 10-bit shift.
    alu_control = 4'b0110; a = 32'h0000_0003; b = 32'd10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_shift_ready_low", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_zero", {31'd0, zero}, 32'd1);
    check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    run_op(4'b0000, 32'd1, 32'd1, res, z, lat);
    check("post_rst_add", res, 32'd2);
    check("post_rst_lat", lat, 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) check($sformatf("no_spurious_%0d", k), {31'd0, out_valid}, 32'd0);
    end

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  c;
      logic [31:0] x, y;
      c = 4'($urandom_range(0, 15));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (x[3:0] == 4'd0) x = 32'hFFFF_FFFF;
      run_op(c, x, y, res, z, lat);
      check($sformatf("rnd%0d_op%0d_result", i, c), res, ref_alu(c, x, y));
      check($sformatf("rnd%0d_zero", i), {31'd0, z}, {31'd0, ref_alu(c, x, y) == 32'd0});
      check($sformatf("rnd%0d_latency", i), lat, ref_lat(c, y));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
